// File: rtl/pipe_sched.sv
// Pipeline hazard scheduler: load-use and divider interlocks, plus jump redirect and flush control.
// Stall and redirect outputs are combinational off decode/execute; tracking state is registered.
module pipe_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_we_i,
  input  logic        id_is_load_i,
  input  logic        id_is_div_i,
  input  logic        ex_jump_flag_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        div_done_i,
  output logic [1:0]  hold_o,
  output logic        bubble_o,
  output logic        flush_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        div_start_o,
  output logic [4:0]  div_rd_o,
  output logic        busy_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [1:0] {RUN, DIV_BUSY, FLUSH} state_e;

  state_e      state_q, state_d;
  logic        flushSub_q, flushSub_d;
  logic        loadPend_q, loadPend_d;
  logic [4:0]  loadRd_q, loadRd_d;
  logic [4:0]  divRd_q, divRd_d;
  logic [15:0] stallCnt_q, stallCnt_d;

  logic jump, inFlush, effValid;
  logic loadMatch, divMatch, loadStall, divStall, stall;
  logic divIssue, loadRecord;

  // Combinational outputs are gated by rst so everything reads zero while reset is held.
  assign jump     = ex_jump_flag_i & ~rst;
  assign inFlush  = (state_q == FLUSH) | flushSub_q;
  assign effValid = id_valid_i & ~inFlush & ~ex_jump_flag_i & ~rst;

  assign loadMatch = (loadRd_q != 5'd0) &
                     ((id_rs1_used_i & (id_rs1_i == loadRd_q)) |
                      (id_rs2_used_i & (id_rs2_i == loadRd_q)));
  assign divMatch  = (divRd_q != 5'd0) &
                     ((id_rs1_used_i & (id_rs1_i == divRd_q)) |
                      (id_rs2_used_i & (id_rs2_i == divRd_q)));

  assign loadStall = effValid & loadPend_q & loadMatch;
  // A second divide, a WAW on the tracked rd, or a RAW on it must wait for the divider.
  assign divStall  = effValid & (state_q == DIV_BUSY) &
                     (divMatch | (id_we_i & (id_rd_i == divRd_q)) | id_is_div_i);
  assign stall     = loadStall | divStall;

  assign divIssue   = effValid & (state_q == RUN) & id_is_div_i & ~stall;
  assign loadRecord = effValid & ~stall & id_is_load_i & id_we_i & (id_rd_i != 5'd0);

  assign hold_o      = {2{stall}};
  assign bubble_o    = stall;
  assign flush_o     = jump | inFlush;
  assign jump_flag_o = jump;
  assign jump_addr_o = jump ? ex_jump_addr_i : 32'd0;
  assign div_start_o = divIssue;
  assign div_rd_o    = divRd_q;
  assign busy_o      = (state_q == DIV_BUSY);
  assign stall_cnt_o = stallCnt_q;

  always_comb begin
    state_d    = state_q;
    flushSub_d = 1'b0;
    divRd_d    = divRd_q;
    unique case (state_q)
      RUN: begin
        if (jump) begin
          state_d = FLUSH;
        end else if (divIssue) begin
          state_d = DIV_BUSY;
          divRd_d = id_rd_i;
        end
      end
      FLUSH:    state_d = jump ? FLUSH : RUN;
      // A redirect while the divider runs keeps DIV_BUSY and flushes through the side flag.
      DIV_BUSY: begin
        if (div_done_i) state_d = jump ? FLUSH : RUN;
        else            flushSub_d = jump;
      end
      default:  state_d = RUN;
    endcase

    loadPend_d = loadRecord;
    loadRd_d   = loadRecord ? id_rd_i : loadRd_q;
    stallCnt_d = (stall && (stallCnt_q != 16'hFFFF)) ? stallCnt_q + 16'd1 : stallCnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      flushSub_q <= 1'b0;
      loadPend_q <= 1'b0;
      loadRd_q   <= 5'd0;
      divRd_q    <= 5'd0;
      stallCnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      flushSub_q <= flushSub_d;
      loadPend_q <= loadPend_d;
      loadRd_q   <= loadRd_d;
      divRd_q    <= divRd_d;
      stallCnt_q <= stallCnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_sched.sv
// Scoreboard bench for pipe_sched: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_pipe_sched;

  typedef struct packed {
    logic        rst;
    logic        valid;
    logic [4:0]  rs1;
    logic        rs1u;
    logic [4:0]  rs2;
    logic        rs2u;
    logic [4:0]  rd;
    logic        we;
    logic        ld;
    logic        dv;
    logic        jump;
    logic [31:0] jaddr;
    logic        done;
  } stim_t;

  typedef struct packed {
    logic [1:0]  hold;
    logic        bubble;
    logic        flush;
    logic        jflag;
    logic [31:0] jaddr;
    logic        dstart;
    logic [4:0]  divRd;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        id_rs1_used_i, id_rs2_used_i, id_we_i, id_is_load_i, id_is_div_i;
  logic        ex_jump_flag_i;
  logic [31:0] ex_jump_addr_i;
  logic        div_done_i;
  logic [1:0]  hold_o;
  logic        bubble_o, flush_o, jump_flag_o, div_start_o, busy_o;
  logic [31:0] jump_addr_o;
  logic [4:0]  div_rd_o;
  logic [15:0] stall_cnt_o;

  exp_t  expQ[$];
  string nameQ[$];
  exp_t  monExp;
  string monName;
  int    testsRun = 0;
  int    failCount = 0;

  pipe_sched dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .id_rd_i(id_rd_i), .id_we_i(id_we_i), .id_is_load_i(id_is_load_i), .id_is_div_i(id_is_div_i),
    .ex_jump_flag_i(ex_jump_flag_i), .ex_jump_addr_i(ex_jump_addr_i), .div_done_i(div_done_i),
    .hold_o(hold_o), .bubble_o(bubble_o), .flush_o(flush_o),
    .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o),
    .div_start_o(div_start_o), .div_rd_o(div_rd_o), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mkInstr(input logic [4:0] rs1, input logic rs1u,
                                    input logic [4:0] rs2, input logic rs2u,
                                    input logic [4:0] rd, input logic we,
                                    input logic ld, input logic dv);
    stim_t s;
    s = '0;
    s.valid = 1'b1;
    s.rs1 = rs1; s.rs1u = rs1u; s.rs2 = rs2; s.rs2u = rs2u;
    s.rd = rd; s.we = we; s.ld = ld; s.dv = dv;
    return s;
  endfunction

  function automatic exp_t mkExp(input logic [1:0] hold, input logic bubble, input logic flush,
                                 input logic jf, input logic [31:0] ja, input logic ds,
                                 input logic [4:0] dr, input logic busy, input logic [15:0] cnt);
    exp_t e;
    e.hold = hold; e.bubble = bubble; e.flush = flush; e.jflag = jf; e.jaddr = ja;
    e.dstart = ds; e.divRd = dr; e.busy = busy; e.cnt = cnt;
    return e;
  endfunction

  // Drive one decode cycle just after the rising edge and queue what the DUT must show in it.
  task automatic applyStimulus(input string nm, input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    rst            = s.rst;
    id_valid_i     = s.valid;
    id_rs1_i       = s.rs1;
    id_rs1_used_i  = s.rs1u;
    id_rs2_i       = s.rs2;
    id_rs2_used_i  = s.rs2u;
    id_rd_i        = s.rd;
    id_we_i        = s.we;
    id_is_load_i   = s.ld;
    id_is_div_i    = s.dv;
    ex_jump_flag_i = s.jump;
    ex_jump_addr_i = s.jaddr;
    div_done_i     = s.done;
    expQ.push_back(e);
    nameQ.push_back(nm);
  endtask

  task automatic checkOutput(input string nm, input exp_t e);
    exp_t act;
    act = {hold_o, bubble_o, flush_o, jump_flag_o, jump_addr_o, div_start_o, div_rd_o, busy_o, stall_cnt_o};
    testsRun++;
    if (act !== e) begin
      failCount++;
      $display("[TB] FAIL %s: got hold=%b bub=%b fl=%b jf=%b ja=%h ds=%b drd=%0d busy=%b cnt=%0d, expected hold=%b bub=%b fl=%b jf=%b ja=%h ds=%b drd=%0d busy=%b cnt=%0d",
               nm, act.hold, act.bubble, act.flush, act.jflag, act.jaddr, act.dstart, act.divRd, act.busy, act.cnt,
               e.hold, e.bubble, e.flush, e.jflag, e.jaddr, e.dstart, e.divRd, e.busy, e.cnt);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      monExp  = expQ.pop_front();
      monName = nameQ.pop_front();
      checkOutput(monName, monExp);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    stim_t nop;
    stim_t addDep;
    nop = '0;
    rst = 1'b1;
    id_valid_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
    id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0; id_we_i = 1'b0;
    id_is_load_i = 1'b0; id_is_div_i = 1'b0;
    ex_jump_flag_i = 1'b0; ex_jump_addr_i = '0; div_done_i = 1'b0;

    s = nop; s.rst = 1'b1;
    applyStimulus("reset", s, mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd0, 0, 16'd0));

    // load x5 ; add x6,x5,x1 stalls exactly one cycle
    applyStimulus("lu_load", mkInstr(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0), mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd0, 0, 16'd0));
    addDep = mkInstr(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0);
    applyStimulus("lu_stall", addDep, mkExp(2'b11, 1, 0, 0, 32'h0, 0, 5'd0, 0, 16'd0));
    applyStimulus("lu_release", addDep, mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd0, 0, 16'd1));

    // x0 is never a hazard; an unused source field does not match
    applyStimulus("x0_load", mkInstr(5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0), mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd0, 0, 16'd1));
    applyStimulus("x0_use", mkInstr(5'd0, 1, 5'd0, 1, 5'd6, 1, 0, 0), mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd0, 0, 16'd1));
    applyStimulus("unused_load", mkInstr(5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0), mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd0, 0, 16'd1));
    applyStimulus("unused_src", mkInstr(5'd7, 0, 5'd3, 1, 5'd9, 1, 0, 0), mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd0, 0, 16'd1));
    applyStimulus("rs2_load", mkInstr(5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0), mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd0, 0, 16'd1));
    s = mkInstr(5'd3, 1, 5'd8, 1, 5'd9, 1, 0, 0);
    applyStimulus("rs2_stall", s, mkExp(2'b11, 1, 0, 0, 32'h0, 0, 5'd0, 0, 16'd1));
    applyStimulus("rs2_release", s, mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd0, 0, 16'd2));

    // div x7 then independent add: no stall, busy until done
    applyStimulus("ind_div", mkInstr(5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 1), mkExp(2'b00, 0, 0, 0, 32'h0, 1, 5'd0, 0, 16'd2));
    applyStimulus("ind_add", mkInstr(5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 0), mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd7, 1, 16'd2));
    applyStimulus("ind_idle", nop, mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd7, 1, 16'd2));
    s = nop; s.done = 1'b1;
    applyStimulus("ind_done", s, mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd7, 1, 16'd2));
    applyStimulus("ind_after", nop, mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd7, 0, 16'd2));

    // div x7 then add x8,x7,x2 stalls 33 cycles, the last with div_done_i
    applyStimulus("dep_div", mkInstr(5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 1), mkExp(2'b00, 0, 0, 0, 32'h0, 1, 5'd7, 0, 16'd2));
    addDep = mkInstr(5'd7, 1, 5'd2, 1, 5'd8, 1, 0, 0);
    for (int k = 0; k < 33; k++) begin
      s = addDep; s.done = (k == 32);
      applyStimulus($sformatf("dep_stall%0d", k), s, mkExp(2'b11, 1, 0, 0, 32'h0, 0, 5'd7, 1, 16'(2 + k)));
    end
    applyStimulus("dep_release", addDep, mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd7, 0, 16'd35));

    // a new div in the done cycle still stalls, then issues
    applyStimulus("bb_div1", mkInstr(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 1), mkExp(2'b00, 0, 0, 0, 32'h0, 1, 5'd7, 0, 16'd35));
    s = mkInstr(5'd1, 1, 5'd2, 1, 5'd4, 1, 0, 1); s.done = 1'b1;
    applyStimulus("bb_div2_stall", s, mkExp(2'b11, 1, 0, 0, 32'h0, 0, 5'd3, 1, 16'd35));
    applyStimulus("bb_div2_issue", mkInstr(5'd1, 1, 5'd2, 1, 5'd4, 1, 0, 1), mkExp(2'b00, 0, 0, 0, 32'h0, 1, 5'd3, 0, 16'd36));
    applyStimulus("bb_idle", nop, mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd4, 1, 16'd36));

    // jump while the divider is busy: flush sub-state, divider still tracked
    s = mkInstr(5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 1); s.jump = 1'b1; s.jaddr = 32'h0000_0200;
    applyStimulus("dj_jump", s, mkExp(2'b00, 0, 1, 1, 32'h0000_0200, 0, 5'd4, 1, 16'd36));
    addDep = mkInstr(5'd4, 1, 5'd2, 1, 5'd9, 1, 0, 0);
    applyStimulus("dj_flush", addDep, mkExp(2'b00, 0, 1, 0, 32'h0, 0, 5'd4, 1, 16'd36));
    applyStimulus("dj_stall", addDep, mkExp(2'b11, 1, 0, 0, 32'h0, 0, 5'd4, 1, 16'd36));
    s = addDep; s.done = 1'b1;
    applyStimulus("dj_done", s, mkExp(2'b11, 1, 0, 0, 32'h0, 0, 5'd4, 1, 16'd37));
    applyStimulus("dj_release", addDep, mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd4, 0, 16'd38));

    // jump from RUN with a concurrent load-use: redirect wins, flush two cycles, no stall
    applyStimulus("jr_load", mkInstr(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0), mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd4, 0, 16'd38));
    addDep = mkInstr(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0);
    s = addDep; s.jump = 1'b1; s.jaddr = 32'h0000_0100;
    applyStimulus("jr_jump", s, mkExp(2'b00, 0, 1, 1, 32'h0000_0100, 0, 5'd4, 0, 16'd38));
    applyStimulus("jr_flush", addDep, mkExp(2'b00, 0, 1, 0, 32'h0, 0, 5'd4, 0, 16'd38));
    applyStimulus("jr_run", addDep, mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd4, 0, 16'd38));

    // reset pulse mid-divide clears everything immediately
    applyStimulus("rd_div", mkInstr(5'd1, 1, 5'd2, 1, 5'd7, 1, 0, 1), mkExp(2'b00, 0, 0, 0, 32'h0, 1, 5'd4, 0, 16'd38));
    applyStimulus("rd_busy", nop, mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd7, 1, 16'd38));
    s = mkInstr(5'd7, 1, 5'd2, 1, 5'd8, 1, 0, 1); s.rst = 1'b1; s.jump = 1'b1; s.jaddr = 32'h0000_0300;
    applyStimulus("rd_reset", s, mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd0, 0, 16'd0));
    applyStimulus("rd_post_add", mkInstr(5'd7, 1, 5'd2, 1, 5'd8, 1, 0, 0), mkExp(2'b00, 0, 0, 0, 32'h0, 0, 5'd0, 0, 16'd0));
    applyStimulus("rd_post_div", mkInstr(5'd1, 1, 5'd2, 1, 5'd1, 1, 0, 1), mkExp(2'b00, 0, 0, 0, 32'h0, 1, 5'd0, 0, 16'd0));

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      testsRun++;
      failCount++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/pipe_sched.md
PIPE_SCHED -- requirements
Module: pipe_sched

Interface
REQ-001 SHALL: clk  in  1  single core clock; all state on rising edge.
REQ-002 SHALL: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL: id_valid_i  in  1  decode stage holds a real instruction.
REQ-004 SHALL: id_rs1_i, id_rs2_i  in  5 each  source register addresses from decode.
REQ-005 SHALL: id_rs1_used_i, id_rs2_used_i  in  1 each  source actually read.
REQ-006 SHALL: id_rd_i  in  5  destination register; id_we_i  in  1  destination written.
REQ-007 SHALL: id_is_load_i, id_is_div_i  in  1 each  load class; DIV/DIVU/REM/REMU class.
REQ-008 SHALL: ex_jump_flag_i  in  1  taken jump/branch from execute; ex_jump_addr_i  in  32  target.
REQ-009 SHALL: div_done_i  in  1  divider result written back this cycle.
REQ-010 SHALL: hold_o  out  2  bit0 hold PC, bit1 hold IF/ID register.
REQ-011 SHALL: bubble_o  out  1  insert NOP into ID/EX; flush_o  out  1  squash IF/ID and ID/EX.
REQ-012 SHALL: jump_flag_o  out  1, jump_addr_o  out  32  redirect to PC register.
REQ-013 SHALL: div_start_o  out  1  one-cycle divider launch; div_rd_o  out  5  tracked divider destination.
REQ-014 SHALL: busy_o  out  1  divider outstanding; stall_cnt_o  out  16  stall-cycle count.

Function
REQ-015 SHALL: FSM states RUN, DIV_BUSY, FLUSH, with one flag plus a load scoreboard entry (load_pend, load_rd).
REQ-016 SHALL: "eff_valid" = id_valid_i and state/flush sub-state not FLUSH and ex_jump_flag_i=0.
REQ-017 SHALL: source match = (rs1_used & rs1==R) or (rs2_used & rs2==R), R!=0; x0 never matches.
REQ-018 SHALL: load-use stall when eff_valid, load_pend=1, and source match on load_rd; lasts exactly 1 cycle.
REQ-019 SHALL: div stall in DIV_BUSY when eff_valid and (source match on div_rd, or id_we_i & id_rd_i==div_rd, or id_is_div_i).
REQ-020 SHALL: on any stall: hold_o=2'b11, bubble_o=1, no div_start_o, no load record, stall_cnt_o +1 (saturate at 16'hFFFF).
REQ-021 SHALL: load record: no stall, eff_valid, id_is_load_i, id_we_i, id_rd_i!=0 -> load_pend<=1, load_rd<=id_rd_i; otherwise load_pend<=0 next cycle.
REQ-022 SHALL: RUN + eff_valid + id_is_div_i + no stall -> div_start_o=1 (combinational, same cycle), div_rd_o<=id_rd_i, state<=DIV_BUSY.
REQ-023 SHALL: DIV_BUSY + div_done_i -> state<=RUN next edge; new div in same cycle still stalls, issues next cycle.
REQ-024 SHALL: ex_jump_flag_i=1 -> same cycle jump_flag_o=1, jump_addr_o=ex_jump_addr_i, flush_o=1, hold_o=0, bubble_o=0, no div_start_o, no load record.
REQ-025 SHALL: jump from RUN -> FLUSH for exactly 1 cycle (flush_o=1, eff_valid=0), then RUN.
REQ-026 SHALL: jump in DIV_BUSY keeps divider outstanding; 1-cycle flush sub-state tracked; div_done_i still honored.
REQ-027 SHALL: jump_addr_o=0 whenever jump_flag_o=0.
REQ-028 SHALL: busy_o=1 exactly in DIV_BUSY.
REQ-029 SHALL: priority: rst > ex_jump_flag_i > div_done_i > stall > issue.

Reset
REQ-030 SHALL: rst=1 asynchronously: state=RUN, load_pend=0, load_rd=0, div_rd_o=0, stall_cnt_o=0, all other outputs 0.
REQ-031 SHALL: reset mid-DIV_BUSY aborts tracking; first post-reset cycle behaves as RUN with empty scoreboard.

Verification
REQ-032 SHALL: load x5, then add x6,x5,x1 -> 1 cycle hold_o=2'b11, bubble_o=1, stall_cnt_o=1; next cycle no stall.
REQ-033 SHALL: div x7 then add x8,x7,x2, div_done_i after 33 cycles -> div_start_o one pulse, div_rd_o=7, 33 stall cycles, busy_o falls after done.
REQ-034 SHALL: div x7 then independent add x9,x1,x2 -> no stall, busy_o=1 until div_done_i.
REQ-035 SHALL: ex_jump_flag_i=1, addr 32'h0000_0100, concurrent load-use -> jump_flag_o=1, jump_addr_o=32'h100, flush_o 2 cycles, no stall, stall_cnt_o unchanged.
REQ-036 SHALL: load x0 followed by consumer of x0 -> no stall.
REQ-037 SHALL: rst pulse during DIV_BUSY -> all outputs 0 immediately, busy_o=0, stall_cnt_o=0.
